// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises 24-bit pixels into a WS2812 NRZ bitstream, MSB first,
// and holds the line low for a latch gap after each frame-ending pixel.
module ws2812_tx #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 63,
  parameter int TRET = 2500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_serial,
  output logic        o_busy
);
  localparam int CW = $clog2(TBIT);
  localparam int GW = $clog2(TRET + 1);
  localparam logic [1:0] GAP  = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;
  if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TRET > 0)) begin : g_bad_params
    $error("ws2812_tx: parameters must satisfy 0 < T0H < T1H < TBIT and TRET > 0");
  end
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic [23:0]   sh;
  logic [4:0]    idx;
  logic          last;
  logic [CW-1:0] hi_end;
  logic          bit_end;
  logic          take;
  assign hi_end  = sh[23] ? CW'(T1H - 1) : CW'(T0H - 1);
  assign bit_end = cnt == CW'(TBIT - 1);
  // Ready also on the very last cycle of bit 0 so a chained pixel starts with no gap.
  assign o_ready = state == IDLE || (state == LOW && bit_end && idx == 5'd0 && !last);
  assign take    = i_valid & o_ready;
  assign o_busy  = state != IDLE;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= GAP;
      cnt      <= '0;
      gcnt     <= '0;
      sh       <= '0;
      idx      <= '0;
      last     <= 1'b0;
      o_serial <= 1'b0;
    end else if (take) begin
      state    <= HIGH;
      sh       <= i_data;
      last     <= i_last;
      idx      <= 5'd23;
      cnt      <= '0;
      o_serial <= 1'b1;
    end else begin
      case (state)
        GAP:
          if (gcnt == GW'(TRET - 1)) begin
            state <= IDLE;
            gcnt  <= '0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        HIGH: begin
          cnt <= cnt + 1'b1;
          if (cnt == hi_end) begin
            state    <= LOW;
            o_serial <= 1'b0;
          end
        end
        LOW:
          if (!bit_end) begin
            cnt <= cnt + 1'b1;
          end else if (idx != 5'd0) begin
            sh       <= sh << 1;
            idx      <= idx - 1'b1;
            cnt      <= '0;
            state    <= HIGH;
            o_serial <= 1'b1;
          end else begin
            cnt   <= '0;
            state <= last ? GAP : IDLE;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: decodes the serial line into words and checks them, with
// their pulse timing, against a scoreboard filled at each handshake.
module tb_ws2812_tx;
  localparam int T0H = 20, T1H = 40, TBIT = 63, TRET = 2500;
  logic clk = 0, rst = 1, i_valid = 0, i_last = 0;
  logic [23:0] i_data = '0;
  logic o_ready, o_serial, o_busy;
  ws2812_tx #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRET(TRET)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_serial(o_serial), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  typedef struct {logic [23:0] word; int hi; bit chained;} exp_t;
  typedef struct {logic [23:0] data; bit last; bit keep; bit noise; bit chained; int exp_hi;} vec_t;
  exp_t q[$];
  exp_t e;
  vec_t v[4];
  int n_tests = 0, n_fail = 0, cyc = 0, hs = 0;
  int nb = 0, last_rise = 0, pfirst = 0, gap = 0, hi = 0, w = 0, pix_done = 0;
  logic prev = 0;
  logic [23:0] word = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev = 0; nb = 0; hi = 0; word = '0;
    end else begin
      if (o_serial && !prev) begin
        if (nb == 0) begin
          pfirst = cyc;
          gap = cyc - last_rise;
        end else chk("bit_period", cyc - last_rise, TBIT);
        last_rise = cyc;
      end
      if (!o_serial && prev) begin
        w = cyc - last_rise;
        chk("pulse_width_legal", w == T1H || w == T0H, 1);
        word = {word[22:0], w == T1H};
        hi += w;
        nb++;
        if (nb == 24) begin
          if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_pixel: got %06h expected none", word);
          end else begin
            e = q.pop_front();
            chk("word", word, e.word);
            chk("hi_cycles", hi, e.hi);
            chk("pixel_span", last_rise - pfirst + TBIT, 24 * TBIT);
            if (e.chained) chk("chain_gap", gap, TBIT);
          end
          nb = 0; hi = 0; word = '0; pix_done++;
        end
      end
      prev = o_serial;
    end
  end
  task automatic send(input logic [23:0] d, input bit l, input bit keep, input bit noise,
                      input bit chained, input int exp_hi);
    int n = 0;
    i_valid = 1; i_last = l; i_data = d;
    while (!o_ready && n < 20000) begin
      if (noise) begin
        i_data = 24'($urandom);
        i_last = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", n < 20000, 1);
    i_data = d; i_last = l;
    q.push_back('{d, exp_hi, chained});
    @(posedge clk);
    #1;
    hs = cyc;
    if (!keep) i_valid = 0;
  endtask
  task automatic wait_ready(output int n, output int bad);
    n = 0; bad = 0;
    while (!o_ready && n < 10000) begin
      bad += int'(o_serial);
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n, bad;
    v[0] = '{24'hFF00FF, 1, 0, 0, 0, 800};
    v[1] = '{24'h123456, 0, 1, 0, 0, 660};
    v[2] = '{24'hABCDEF, 1, 0, 1, 1, 820};
    v[3] = '{24'h000001, 0, 0, 0, 0, 500};
    repeat (3) @(negedge clk);
    chk("reset_serial", o_serial, 0);
    chk("reset_ready", o_ready, 0);
    chk("reset_busy", o_busy, 1);
    rst = 0;
    wait_ready(n, bad);
    chk("por_gap", n, TRET);
    chk("por_gap_serial", bad, 0);
    chk("por_idle_busy", o_busy, 0);
    for (int i = 0; i < 4; i++) begin
      send(v[i].data, v[i].last, v[i].keep, v[i].noise, v[i].chained, v[i].exp_hi);
      if (v[i].last) begin
        wait_ready(n, bad);
        chk("frame_to_ready", cyc - hs, 24 * TBIT + TRET);
        chk("gap_serial", o_serial, 0);
        chk("gap_idle_busy", o_busy, 0);
      end
    end
    repeat (24 * TBIT + 100) @(negedge clk);
    chk("idle_ready", o_ready, 1);
    chk("idle_serial", o_serial, 0);
    chk("idle_busy", o_busy, 0);
    chk("pixels_seen", pix_done, 4);
    send(24'h800000, 1, 0, 0, 0, 500);
    @(negedge clk);
    #1;
    chk("rise_latency", pfirst, hs);
    wait_ready(n, bad);
    chk("frame_to_ready2", cyc - hs, 24 * TBIT + TRET);
    send(24'hAAAAAA, 1, 0, 0, 0, 720);
    n = 0;
    while (!(nb == 13 && o_serial) && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("bit10_reached", n < 5000, 1);
    #1;
    rst = 1;
    #1;
    chk("async_rst_serial", o_serial, 0);
    chk("async_rst_ready", o_ready, 0);
    chk("async_rst_busy", o_busy, 1);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 0;
    wait_ready(n, bad);
    chk("rst_gap", n, TRET);
    chk("rst_gap_serial", bad, 0);
    send(24'h5A5A5A, 1, 0, 0, 0, 720);
    wait_ready(n, bad);
    chk("frame_to_ready3", cyc - hs, 24 * TBIT + TRET);
    chk("pixels_total", pix_done, 6);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Pixel serialiser that sits directly upstream of the `led` chain. It accepts 24-bit colour words over a valid/ready handshake and drives the single-wire NRZ bitstream (MSB first, high-time-coded bits) into the first `led` `i_serial` input. At the end of each frame it inserts the reset/latch gap so the chain latches `o_led_data`.

## Interface

- `T0H`, default 20: high time of a `0` bit, in clocks (400 ns at 50 MHz).
- `T1H`, default 40: high time of a `1` bit, in clocks (800 ns).
- `TBIT`, default 63: total bit period, in clocks (1.26 us).
- `TRET`, default 2500: latch/reset gap, line held low, in clocks (50 us). Must be at least `` `RET `` expressed in clocks.
- Constraint: 0 < `T0H` < `T1H` < `TBIT`. Violating this is a parameter error and must be flagged at elaboration.
- `i_clk` input 1: the block's single clock.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_data` input 24: pixel word, sent bit 23 first.
- `i_valid` input 1: `i_data`/`i_last` valid.
- `i_last` input 1: this pixel ends the frame; a TRET gap follows it.
- `o_ready` output 1: the block accepts a pixel this cycle.
- `o_serial` output 1: NRZ line to `led.i_serial`. Registered.
- `o_busy` output 1: high whenever state is not IDLE.

## Operation

- States:
  - GAP: line low, counting TRET.
  - IDLE: line low, ready.
  - HIGH: high phase of the current bit.
  - LOW: low phase of the current bit.
- Reset values, forced asynchronously while `i_rst`=1:
  - state=GAP, counters=0, shift register=0, last flag=0.
  - `o_serial`=0, `o_ready`=0, `o_busy`=1.
- GAP: hold `o_serial`=0 for TRET cycles, then go to IDLE. GAP is entered after reset and after any pixel flagged `i_last`.
- IDLE: `o_ready`=1. On `i_valid`&`o_ready`, load `i_data` into the shift register, capture `i_last`, set bit index to 23, and go to HIGH.
- HIGH: `o_serial`=1 for `T1H` cycles if the current bit is 1, or `T0H` cycles if it is 0. Then go to LOW.
- LOW: `o_serial`=0 for the remaining cycles of the bit period (`TBIT`−`T1H` or `TBIT`−`T0H`).
  - If it is not the final bit: shift left, decrement the index, go to HIGH.
  - If it is the final bit and the last flag is set: go to GAP.
  - If it is the final bit, the last flag is clear, and a handshake occurs: reload and go to HIGH.
  - Otherwise: go to IDLE.
- `o_ready`:
  - 1 in IDLE.
  - 1 in the final cycle of bit 0's LOW phase when the last flag is clear (back-to-back chaining).
  - 0 everywhere else.
- `i_data`/`i_last` are sampled only on a handshake. Values presented while `o_ready`=0 are ignored.
- Idle time between pixels with the last flag clear is the host's responsibility. The block does not insert a gap.
- Bit-period counter width: clog2(`TBIT`). GAP counter width: clog2(`TRET`+1). Counters never wrap during normal operation.

## Timing

- Handshake at cycle k: `o_serial` rises at k+1.
- Each bit occupies exactly `TBIT` cycles. A pixel occupies exactly 24·`TBIT` cycles (1512 with defaults).
- Back-to-back handshake: the new pixel's first rising edge is exactly `TBIT` cycles after the previous bit-0 rising edge, with zero extra cycles.
- After an `i_last` pixel:
  - `o_serial` stays low for TRET cycles plus bit 0's LOW phase.
  - `o_ready` returns to 1 on the cycle after GAP completes.
- Reset mid-operation: `o_serial` goes to 0 immediately (asynchronous). After `i_rst` deasserts, a full TRET gap runs before `o_ready`=1. The partially sent pixel is discarded.
- Simultaneous `i_valid` with `o_ready`=0: there is no acceptance and no state change.

## Test plan

- Reset, then deassert: `o_ready`=0 and `o_serial`=0 for exactly 2500 cycles, then `o_ready`=1 and `o_busy`=0.
- Send 24'hFF00FF with `i_last`=1.
  - Expected pulses: 8 pulses of 40 high/23 low, then 8 of 20/43, then 8 of 40/23. Total 1512 cycles.
  - Then 2500 low cycles with `o_ready`=0.
  - A downstream `led` instance reports `o_led_data`=24'hFF00FF.
- Back-to-back 24'h123456 (`i_last`=0) then 24'hABCDEF (`i_last`=1), `i_valid` held high:
  - The gap between the last rising edge of pixel 1 and the first of pixel 2 is exactly 63 cycles.
  - A two-`led` chain latches both words.
- Send 24'h000001 (`i_last`=0), then drop `i_valid` for 100 cycles:
  - The block returns to IDLE with `o_serial`=0 and `o_ready`=1.
  - On the next handshake, `o_serial` rises one cycle later.
- Assert `i_rst` mid-HIGH of bit 10:
  - `o_serial`=0 in the same cycle.
  - After deassert, 2500-cycle gap, then `o_ready`=1.
- Toggle `i_data` randomly while `o_ready`=0 during a pixel: the emitted bitstream matches only the handshaken word.
